// File: rtl/icache_ctrl.sv
// Direct-mapped I-cache controller: register tag/valid array, 4-word line fill from the memory bus.
// Hits answer 1 cycle after the request; a miss stalls the requester until 2 cycles after the last fill ack.
module icache_ctrl #(
  parameter int RAMADDRBITS = 5,
  parameter int LINEBITS    = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            cpu_addr,
  input  logic                   cpu_req,
  output logic                   cpu_ready,
  output logic [31:0]            cpu_data,
  input  logic                   inval,
  output logic [31:0]            mem_addr,
  output logic                   mem_req,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rdata,
  output logic [RAMADDRBITS-1:0] ram_addr,
  output logic                   ram_we,
  output logic [31:0]            ram_wdata,
  input  logic [31:0]            ram_rdata
);

  localparam int IDXBITS = RAMADDRBITS - LINEBITS;
  localparam int NLINES  = 1 << IDXBITS;
  localparam int TAGBITS = 30 - RAMADDRBITS;

  typedef enum logic {IDLE, FILL} state_t;

  state_t               state;
  logic [NLINES-1:0]    valid;
  logic [TAGBITS-1:0]   tags [NLINES];
  logic                 suppress;
  logic [LINEBITS-1:0]  counter;
  logic [IDXBITS-1:0]   fill_index;
  logic [TAGBITS-1:0]   fill_tag;

  logic [LINEBITS-1:0]  req_word;
  logic [IDXBITS-1:0]   req_index;
  logic [TAGBITS-1:0]   req_tag;
  logic                 hit;
  logic                 ack;
  logic                 last_ack;
  logic                 unused_addr_bits;

  assign req_word         = cpu_addr[2 +: LINEBITS];
  assign req_index        = cpu_addr[2 + LINEBITS +: IDXBITS];
  assign req_tag          = cpu_addr[31 -: TAGBITS];
  assign unused_addr_bits = &{1'b0, cpu_addr[1:0]};

  assign hit      = valid[req_index] && (tags[req_index] == req_tag);
  // Acks are only meaningful while a read is outstanding.
  assign ack      = mem_req && mem_ack;
  assign last_ack = ack && (counter == {LINEBITS{1'b1}});

  always_comb begin
    ram_wdata = mem_rdata;
    if (state == FILL) begin
      ram_addr = {fill_index, counter};
      ram_we   = ack;
    end else begin
      ram_addr = {req_index, req_word};
      ram_we   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      valid      <= '0;
      suppress   <= 1'b0;
      counter    <= '0;
      fill_index <= '0;
      fill_tag   <= '0;
      cpu_ready  <= 1'b0;
      cpu_data   <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      for (int i = 0; i < NLINES; i++) tags[i] <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (hit) begin
              cpu_data  <= ram_rdata;
              cpu_ready <= 1'b1;
            end else begin
              fill_index <= req_index;
              fill_tag   <= req_tag;
              counter    <= '0;
              suppress   <= 1'b0;
              mem_addr   <= {req_tag, req_index, {LINEBITS{1'b0}}, 2'b00};
              mem_req    <= 1'b1;
              state      <= FILL;
            end
          end
        end
        FILL: begin
          if (ack) begin
            counter  <= counter + 1'b1;
            mem_addr <= mem_addr + 32'd4;
            if (last_ack) begin
              mem_req  <= 1'b0;
              suppress <= 1'b0;
              state    <= IDLE;
              if (!suppress) begin
                valid[fill_index] <= 1'b1;
                tags[fill_index]  <= fill_tag;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Later assignment wins: an invalidate beats a completing line in the same cycle.
      if (inval) begin
        valid <= '0;
        if (state == FILL && !last_ack) suppress <= 1'b1;
      end
    end
  end

endmodule
